ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Two-master, single-port RAM arbiter with round-robin fairness.
// One transaction at a time: IDLE -> ACCESS -> (WAIT x RD_LAT for reads) -> ACK -> IDLE.
module ram_port_arbiter #(
  parameter int AW     = 10,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_gnt;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [1:0]    r_wait_cnt;
  logic          r_last;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic w_any_req;
  logic w_pick;
  logic w_wait_done;

  // r_last holds the master served last; on a tie the other one wins.
  assign w_any_req   = m0_req | m1_req;
  assign w_pick      = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_wait_done = (r_wait_cnt == LAST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_any_req) w_next = ACCESS;
      ACCESS: w_next = r_we ? ACK : WAIT;
      WAIT:   if (w_wait_done) w_next = ACK;
      ACK:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= '0;
      r_last     <= 1'b1;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt   <= w_pick;
            r_we    <= w_pick ? m1_we    : m0_we;
            r_addr  <= w_pick ? m1_addr  : m0_addr;
            r_wdata <= w_pick ? m1_wdata : m0_wdata;
          end
        end
        ACCESS: begin
          r_wait_cnt <= '0;
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt + 2'd1;
          if (w_wait_done) begin
            if (r_gnt) begin
              r_rdata1 <= ram_dout;
            end else begin
              r_rdata0 <= ram_dout;
            end
          end
        end
        ACK: begin
          r_last <= r_gnt;
        end
      endcase
    end
  end

  assign ram_we   = (r_state == ACCESS) & r_we;
  assign ram_addr = r_addr;
  assign ram_din  = r_wdata;
  assign m0_ack   = (r_state == ACK) & ~r_gnt;
  assign m1_ack   = (r_state == ACK) &  r_gnt;
  assign m0_rdata = r_rdata0;
  assign m1_rdata = r_rdata1;
  assign busy     = (r_state != IDLE);
  assign grant_id = busy & r_gnt;

endmodule
